rbus_sink: RTL and testbench

- Write-side endpoint of the R bus: takes the word placed on the R bus and commits it to the selected destination.
- Destinations: general registers R0–R7, address register RA, address pointer RAP, or the store latch SLT, which issues a memory store.
- Sits in the datapath opposite the R-bus source mux and is driven each microcycle by the sequencer's destination field.
- Owns the valid/ready store handshake toward the memory interface and post-increments RAP on each completed store.

---
 rtl/rbus_sink_pkg.sv | 29 ++
 rtl/rbus_sink_store_latch.sv | 58 +++++
 rtl/rbus_sink.sv | 100 ++++++++++
 tb/tb_rbus_sink.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rbus_sink_pkg.sv
// Destination selector codes for the R bus. The numbering matches the R-bus
// source selector so one microcode field layout serves both ends of the bus.
package package_rbus_dest_selector;

  typedef enum logic [3:0] {
    R0  = 4'b0000,
    R1  = 4'b0001,
    R2  = 4'b0010,
    R3  = 4'b0011,
    R4  = 4'b0100,
    R5  = 4'b0101,
    R6  = 4'b0110,
    R7  = 4'b0111,
    RA  = 4'b1000,
    RAP = 4'b1001,
    SLT = 4'b1010,
    NRB = 4'b1111
  } RBUS_DEST_SELECTOR;

  // Store latch states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // Codes 1011..1110 are unassigned; they behave as NRB but get flagged
  function automatic logic is_reserved_dest(input logic [3:0] code);
    return (code >= 4'b1011) && (code <= 4'b1110);
  endfunction

endpackage

// File: rtl/rbus_sink_store_latch.sv
// Store latch: holds one outstanding memory store and runs its valid/ready
// handshake. hs_done pulses in every cycle a store is taken by memory.
module rbus_store_latch
  import package_rbus_dest_selector::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slt_accept,
  input  logic [WIDTH-1:0] slt_data,
  input  logic [WIDTH-1:0] rap_in,
  input  logic             st_ready,
  output logic             st_valid,
  output logic [WIDTH-1:0] st_data,
  output logic [WIDTH-1:0] st_addr,
  output logic             hs_done
);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] addr_q, addr_d;

  assign st_valid = (state_q == ST_PEND);
  assign st_data  = data_q;
  assign st_addr  = addr_q;
  // A store caught by reset is dropped, never reported as completed
  assign hs_done  = st_valid & st_ready & ~reset;

  // Next-state: a new accept reloads the latch (also in a handshake cycle,
  // giving back-to-back stores); otherwise a handshake empties it
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    addr_d  = addr_q;
    if (slt_accept) begin
      state_d = ST_PEND;
      data_d  = slt_data;
      addr_d  = rap_in;
    end else if (hs_done) begin
      state_d = ST_IDLE;
    end
  end

  // State and payload registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: rtl/rbus_sink.sv
// R-bus write endpoint: commits the bus word to R0..R7, RA, RAP or the store
// latch, and post-increments RAP on every completed store.
module rbus_sink
  import package_rbus_dest_selector::*;
#(
  parameter int   WIDTH     = 32,
  parameter int   ADDR_STEP = 4,
  parameter bit   R0_ZERO   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rbus_valid,
  input  RBUS_DEST_SELECTOR     rbus_dest,
  input  logic [WIDTH-1:0]      rbus_data,
  output logic                  rbus_stall,
  output logic [8*WIDTH-1:0]    reg_q,
  output logic [WIDTH-1:0]      ra_q,
  output logic [WIDTH-1:0]      rap_q,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic [WIDTH-1:0]      st_data,
  output logic [WIDTH-1:0]      st_addr,
  output logic                  dest_err
);

  logic [7:0][WIDTH-1:0] regs_q, regs_d;
  logic [WIDTH-1:0]      ra_r_q, ra_d;
  logic [WIDTH-1:0]      rap_r_q, rap_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  slt_accept;
  logic                  hs_done;

  assign reg_q    = regs_q;
  assign ra_q     = ra_r_q;
  assign rap_q    = rap_r_q;
  assign dest_err = err_q;

  // Only an SLT word can stall: the latch is full and memory is not taking it
  assign rbus_stall = ~reset & rbus_valid & (rbus_dest == SLT) & st_valid & ~st_ready;
  assign accept     = rbus_valid & ~rbus_stall;
  assign slt_accept = accept & (rbus_dest == SLT);

  rbus_store_latch #(
    .WIDTH (WIDTH)
  ) u_latch (
    .clk        (clk),
    .reset      (reset),
    .slt_accept (slt_accept),
    .slt_data   (rbus_data),
    .rap_in     (rap_r_q),
    .st_ready   (st_ready),
    .st_valid   (st_valid),
    .st_data    (st_data),
    .st_addr    (st_addr),
    .hs_done    (hs_done)
  );

  // Register-file next state; an explicit RAP write overrides the increment
  always_comb begin
    regs_d = regs_q;
    ra_d   = ra_r_q;
    rap_d  = rap_r_q;
    err_d  = err_q;
    if (hs_done) begin
      rap_d = rap_r_q + WIDTH'(ADDR_STEP);
    end
    if (rbus_valid && is_reserved_dest(rbus_dest)) begin
      err_d = 1'b1;
    end
    if (accept) begin
      case (rbus_dest)
        R0, R1, R2, R3, R4, R5, R6, R7: begin
          if (!(R0_ZERO && (rbus_dest == R0))) begin
            regs_d[rbus_dest[2:0]] = rbus_data;
          end
        end
        RA:      ra_d  = rbus_data;
        RAP:     rap_d = rbus_data;
        default: ;
      endcase
    end
  end

  // Architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q  <= '0;
      ra_r_q  <= '0;
      rap_r_q <= '0;
      err_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      ra_r_q  <= ra_d;
      rap_r_q <= rap_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rbus_sink.sv
// Bench for rbus_sink: a directed table of vectors with hand-computed
// expectations, then random traffic against a behavioural model.
module tb_rbus_sink;
  import package_rbus_dest_selector::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              rbus_valid;
  RBUS_DEST_SELECTOR rbus_dest;
  logic [31:0]       rbus_data;
  logic              st_ready;

  logic              stall, stall_z;
  logic [255:0]      reg_q, reg_q_z;
  logic [31:0]       ra_q, ra_q_z, rap_q, rap_q_z;
  logic              st_valid, st_valid_z;
  logic [31:0]       st_data, st_data_z, st_addr, st_addr_z;
  logic              dest_err, dest_err_z;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rbus_sink #(.WIDTH(32), .ADDR_STEP(4), .R0_ZERO(1'b0)) dut (
    .clk(clk), .reset(reset), .rbus_valid(rbus_valid), .rbus_dest(rbus_dest),
    .rbus_data(rbus_data), .rbus_stall(stall), .reg_q(reg_q), .ra_q(ra_q),
    .rap_q(rap_q), .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .st_addr(st_addr), .dest_err(dest_err)
  );

  rbus_sink #(.WIDTH(32), .ADDR_STEP(4), .R0_ZERO(1'b1)) dut_z (
    .clk(clk), .reset(reset), .rbus_valid(rbus_valid), .rbus_dest(rbus_dest),
    .rbus_data(rbus_data), .rbus_stall(stall_z), .reg_q(reg_q_z), .ra_q(ra_q_z),
    .rap_q(rap_q_z), .st_valid(st_valid_z), .st_ready(st_ready), .st_data(st_data_z),
    .st_addr(st_addr_z), .dest_err(dest_err_z)
  );

  // Behavioural model state
  logic [31:0] m_regs [8];
  logic [31:0] m_regs_z [8];
  logic [31:0] m_ra, m_rap, m_sd, m_sa;
  bit          m_pend, m_err;

  typedef struct {
    bit          rst;
    bit          v;
    logic [3:0]  dest;
    logic [31:0] data;
    bit          rdy;
    bit          e_stall;
    bit          e_stv;
    logic [31:0] e_sa;
    logic [31:0] e_sd;
    logic [31:0] e_rap;
    bit          e_err;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit m_stall(input bit rst, input bit v, input logic [3:0] d, input bit rdy);
    return !rst && v && (d == 4'd10) && m_pend && !rdy;
  endfunction

  // One clock of the architectural rules, applied to the model
  task automatic m_clock(input bit rst, input bit v, input logic [3:0] d,
                         input logic [31:0] data, input bit rdy);
    bit stl, acc, hs;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_regs[i] = 0; m_regs_z[i] = 0; end
      m_ra = 0; m_rap = 0; m_sd = 0; m_sa = 0; m_pend = 0; m_err = 0;
      return;
    end
    stl = m_stall(rst, v, d, rdy);
    acc = v && !stl;
    hs  = m_pend && rdy;
    if (v && d >= 11 && d <= 14) m_err = 1;
    if (acc && d == 4'd10) begin
      m_sd = data; m_sa = m_rap; m_pend = 1;
    end else if (hs) begin
      m_pend = 0;
    end
    if (hs) m_rap = m_rap + 32'd4;
    if (acc) begin
      if (d < 8) begin
        m_regs[d[2:0]] = data;
        if (d != 0) m_regs_z[d[2:0]] = data;
      end else if (d == 8) m_ra = data;
      else if (d == 9) m_rap = data;
    end
  endtask

  function automatic logic [255:0] pack_regs(input bit z);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = z ? m_regs_z[i] : m_regs[i];
    return r;
  endfunction

  // Apply one cycle of inputs, check stall before the edge and state after
  task automatic step(input bit rst, input bit v, input logic [3:0] d,
                      input logic [31:0] data, input bit rdy);
    @(negedge clk);
    reset = rst; rbus_valid = v; rbus_dest = RBUS_DEST_SELECTOR'(d);
    rbus_data = data; st_ready = rdy;
    #1;
    chk("stall_model", {255'd0, stall}, {255'd0, m_stall(rst, v, d, rdy)});
    chk("stall_z_model", {255'd0, stall_z}, {255'd0, m_stall(rst, v, d, rdy)});
    @(posedge clk);
    m_clock(rst, v, d, data, rdy);
    #1;
    chk("reg_q", reg_q, pack_regs(1'b0));
    chk("reg_q_r0zero", reg_q_z, pack_regs(1'b1));
    chk("ra_q", {224'd0, ra_q}, {224'd0, m_ra});
    chk("rap_q", {224'd0, rap_q}, {224'd0, m_rap});
    chk("st_valid", {255'd0, st_valid}, {255'd0, m_pend});
    chk("st_data", {224'd0, st_data}, {224'd0, m_sd});
    chk("st_addr", {224'd0, st_addr}, {224'd0, m_sa});
    chk("dest_err", {255'd0, dest_err}, {255'd0, m_err});
    chk("rap_q_r0zero", {224'd0, rap_q_z}, {224'd0, m_rap});
  endtask

  initial begin
    reset = 1'b1; rbus_valid = 1'b0; rbus_dest = NRB; rbus_data = '0; st_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin m_regs[i] = 0; m_regs_z[i] = 0; end
    m_ra = 0; m_rap = 0; m_sd = 0; m_sa = 0; m_pend = 0; m_err = 0;

    //          rst v  dest   data           rdy  stl stv sa            sd           rap           err
    tbl[0]  = '{1, 0, 4'hF, 32'h0,         0,   0,  0, 32'h0,        32'h0,       32'h0,        0};
    tbl[1]  = '{0, 1, 4'h3, 32'hDEADBEEF,  0,   0,  0, 32'h0,        32'h0,       32'h0,        0};
    tbl[2]  = '{0, 1, 4'hF, 32'h12345678,  0,   0,  0, 32'h0,        32'h0,       32'h0,        0};
    tbl[3]  = '{0, 1, 4'h9, 32'h100,       0,   0,  0, 32'h0,        32'h0,       32'h100,      0};
    tbl[4]  = '{0, 1, 4'hA, 32'h11,        0,   0,  1, 32'h100,      32'h11,      32'h100,      0};
    tbl[5]  = '{0, 0, 4'hF, 32'h0,         0,   0,  1, 32'h100,      32'h11,      32'h100,      0};
    tbl[6]  = '{0, 0, 4'hF, 32'h0,         0,   0,  1, 32'h100,      32'h11,      32'h100,      0};
    tbl[7]  = '{0, 0, 4'hF, 32'h0,         1,   0,  0, 32'h100,      32'h11,      32'h104,      0};
    tbl[8]  = '{0, 1, 4'hA, 32'h33,        0,   0,  1, 32'h104,      32'h33,      32'h104,      0};
    tbl[9]  = '{0, 1, 4'hA, 32'h22,        0,   1,  1, 32'h104,      32'h33,      32'h104,      0};
    tbl[10] = '{0, 1, 4'hA, 32'h22,        1,   0,  1, 32'h104,      32'h22,      32'h108,      0};
    tbl[11] = '{0, 1, 4'hF, 32'h0,         1,   0,  0, 32'h104,      32'h22,      32'h10C,      0};
    tbl[12] = '{0, 1, 4'h9, 32'hFFFFFFFC,  0,   0,  0, 32'h104,      32'h22,      32'hFFFFFFFC, 0};
    tbl[13] = '{0, 1, 4'hA, 32'h44,        0,   0,  1, 32'hFFFFFFFC, 32'h44,      32'hFFFFFFFC, 0};
    tbl[14] = '{0, 0, 4'hF, 32'h0,         1,   0,  0, 32'hFFFFFFFC, 32'h44,      32'h0,        0};
    tbl[15] = '{0, 1, 4'hA, 32'h55,        0,   0,  1, 32'h0,        32'h55,      32'h0,        0};
    tbl[16] = '{0, 1, 4'h9, 32'h40,        1,   0,  0, 32'h0,        32'h55,      32'h40,       0};
    tbl[17] = '{0, 1, 4'hC, 32'h99,        0,   0,  0, 32'h0,        32'h55,      32'h40,       1};
    tbl[18] = '{0, 1, 4'h8, 32'h1234,      0,   0,  0, 32'h0,        32'h55,      32'h40,       1};
    tbl[19] = '{0, 1, 4'hA, 32'h66,        0,   0,  1, 32'h40,       32'h66,      32'h40,       1};
    tbl[20] = '{1, 1, 4'hA, 32'h77,        1,   0,  0, 32'h0,        32'h0,       32'h0,        0};
    tbl[21] = '{0, 1, 4'h0, 32'h5,         0,   0,  0, 32'h0,        32'h0,       32'h0,        0};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset = tbl[i].rst; rbus_valid = tbl[i].v; rbus_dest = RBUS_DEST_SELECTOR'(tbl[i].dest);
      rbus_data = tbl[i].data; st_ready = tbl[i].rdy;
      #1;
      chk("tbl_stall", {255'd0, stall}, {255'd0, tbl[i].e_stall});
      @(posedge clk);
      m_clock(tbl[i].rst, tbl[i].v, tbl[i].dest, tbl[i].data, tbl[i].rdy);
      #1;
      chk("tbl_st_valid", {255'd0, st_valid}, {255'd0, tbl[i].e_stv});
      chk("tbl_st_addr", {224'd0, st_addr}, {224'd0, tbl[i].e_sa});
      chk("tbl_st_data", {224'd0, st_data}, {224'd0, tbl[i].e_sd});
      chk("tbl_rap_q", {224'd0, rap_q}, {224'd0, tbl[i].e_rap});
      chk("tbl_dest_err", {255'd0, dest_err}, {255'd0, tbl[i].e_err});
      chk("tbl_reg_q", reg_q, pack_regs(1'b0));
      chk("tbl_reg_q_r0zero", reg_q_z, pack_regs(1'b1));
      chk("tbl_ra_q", {224'd0, ra_q}, {224'd0, m_ra});
    end

    // Hand-written checks of specific values left by the table
    chk("r3_value", {224'd0, reg_q[3*32 +: 32]}, {224'd0, 32'h0});
    chk("r0_written", {224'd0, reg_q[31:0]}, {224'd0, 32'h5});
    chk("r0_zero_kept", {224'd0, reg_q_z[31:0]}, {224'd0, 32'h0});

    // Write R3 and hold NRB: value visible and stall never raised
    step(1'b0, 1'b1, 4'h3, 32'hDEADBEEF, 1'b0);
    step(1'b0, 1'b1, 4'hF, 32'h0, 1'b0);
    chk("r3_after_nrb", {224'd0, reg_q[3*32 +: 32]}, {224'd0, 32'hDEADBEEF});

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit          r, v, rdy;
      logic [3:0]  d;
      logic [31:0] data;
      r    = ($urandom_range(0, 59) == 0);
      v    = ($urandom_range(0, 3) != 0);
      d    = ($urandom_range(0, 2) == 0) ? 4'hA : 4'($urandom_range(0, 15));
      data = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      rdy  = $urandom_range(0, 1) == 1;
      step(r, v, d, data, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
